// File: rtl/bank_digit_parser.sv
// ASCII-to-digit front end for the digit stack: one digit per cycle through a hold-until-consumed
// output register, newline closes a bank once its last digit is consumed, with per-bank length and sticky errors.
module bank_digit_parser #(
   parameter int  MAX_DIGITS = 128,
   parameter int  DATA_WIDTH = 8,
   localparam int LEN_W      = $clog2(MAX_DIGITS) + 1
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [7:0]            byte_in,
   input  logic                  byte_valid,
   output logic                  byte_ready,
   input  logic                  sink_full,
   output logic [DATA_WIDTH-1:0] digit_out,
   output logic                  digit_valid,
   output logic                  bank_done,
   output logic [LEN_W-1:0]      bank_len,
   output logic [15:0]           bank_count,
   output logic                  err,
   output logic [1:0]            err_code
);

   typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_CLOSE} state_t;

   localparam logic [LEN_W-1:0] MAX_CNT = LEN_W'(MAX_DIGITS);

   state_t                state_q, state_d;
   logic [LEN_W-1:0]      cnt_q, cnt_d;
   logic                  dv_q, dv_d;
   logic [DATA_WIDTH-1:0] dout_q, dout_d;
   logic                  done_q, done_d;
   logic [LEN_W-1:0]      len_q, len_d;
   logic [15:0]           bcnt_q, bcnt_d;
   logic                  err_q, err_d;
   logic [1:0]            code_q, code_d;

   logic       accept;
   logic       consume;
   logic       is_digit;
   logic [7:0] digit_val;

   assign byte_ready = reset && (state_q != S_CLOSE) && (!dv_q || !sink_full);
   assign accept     = byte_valid && byte_ready;
   assign consume    = dv_q && !sink_full;
   assign is_digit   = (byte_in >= 8'h30) && (byte_in <= 8'h39);
   assign digit_val  = byte_in - 8'h30;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      dv_d    = dv_q;
      dout_d  = dout_q;
      done_d  = 1'b0;
      len_d   = len_q;
      bcnt_d  = bcnt_q;
      err_d   = err_q;
      code_d  = code_q;

      if (consume) begin
         dv_d = 1'b0;
      end

      if (accept) begin
         if (is_digit) begin
            if (cnt_q < MAX_CNT) begin
               dv_d    = 1'b1;
               dout_d  = DATA_WIDTH'(digit_val[3:0]);
               cnt_d   = cnt_q + LEN_W'(1);
               state_d = S_COLLECT;
            end else if (!err_q) begin
               err_d  = 1'b1;
               code_d = 2'b10;
            end
         end else if (byte_in == 8'h0A) begin
            // A newline on an empty line is swallowed without closing a bank.
            if (state_q == S_COLLECT) begin
               state_d = S_CLOSE;
            end
         end else if (byte_in != 8'h0D) begin
            if (!err_q) begin
               err_d  = 1'b1;
               code_d = 2'b01;
            end
         end
      end

      // Close only once the last digit has left the output register.
      if ((state_q == S_CLOSE) && !dv_q) begin
         state_d = S_IDLE;
         done_d  = 1'b1;
         len_d   = cnt_q;
         bcnt_d  = bcnt_q + 16'd1;
         cnt_d   = '0;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         dv_q    <= 1'b0;
         dout_q  <= '0;
         done_q  <= 1'b0;
         len_q   <= '0;
         bcnt_q  <= '0;
         err_q   <= 1'b0;
         code_q  <= 2'b00;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         dv_q    <= dv_d;
         dout_q  <= dout_d;
         done_q  <= done_d;
         len_q   <= len_d;
         bcnt_q  <= bcnt_d;
         err_q   <= err_d;
         code_q  <= code_d;
      end
   end

   assign digit_out   = dout_q;
   assign digit_valid = dv_q;
   assign bank_done   = done_q;
   assign bank_len    = len_q;
   assign bank_count  = bcnt_q;
   assign err         = err_q;
   assign err_code    = code_q;

endmodule

// File: tb/tb_bank_digit_parser.sv
// Bench for bank_digit_parser: directed scenarios plus random byte streams against a byte-level model.
module tb_bank_digit_parser;

   localparam int MAXD  = 4;
   localparam int DW    = 8;
   localparam int LEN_W = $clog2(MAXD) + 1;

   logic             clock = 1'b0;
   logic             reset = 1'b1;
   logic [7:0]       byte_in = 8'h00;
   logic             byte_valid = 1'b0;
   logic             byte_ready;
   logic             sink_full = 1'b0;
   logic [DW-1:0]    digit_out;
   logic             digit_valid;
   logic             bank_done;
   logic [LEN_W-1:0] bank_len;
   logic [15:0]      bank_count;
   logic             err;
   logic [1:0]       err_code;

   bank_digit_parser #(.MAX_DIGITS(MAXD), .DATA_WIDTH(DW)) dut (
      .clock(clock), .reset(reset), .byte_in(byte_in), .byte_valid(byte_valid),
      .byte_ready(byte_ready), .sink_full(sink_full), .digit_out(digit_out),
      .digit_valid(digit_valid), .bank_done(bank_done), .bank_len(bank_len),
      .bank_count(bank_count), .err(err), .err_code(err_code)
   );

   always #5 clock = ~clock;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;
   int last_acc_cyc = 0;

   always @(posedge clock) cyc <= cyc + 1;

   // Observed traffic, sampled away from the active edge.
   int obs_dig[$];
   int obs_dcyc[$];
   int obs_len[$];
   int obs_cnt[$];
   int obs_bcyc[$];

   always @(negedge clock) begin
      if (reset) begin
         if (digit_valid && !sink_full) begin
            obs_dig.push_back(int'(digit_out));
            obs_dcyc.push_back(cyc);
         end
         if (bank_done) begin
            obs_len.push_back(int'(bank_len));
            obs_cnt.push_back(int'(bank_count));
            obs_bcyc.push_back(cyc);
         end
      end
   end

   // Reference model: the byte stream interpreted line by line.
   int exp_dig[$];
   int exp_len[$];
   int exp_cnt[$];
   int m_cnt = 0;
   int m_bcnt = 0;
   int m_err = 0;
   int m_code = 0;

   function automatic void model_flag(input int code);
      if (m_err == 0) begin
         m_err  = 1;
         m_code = code;
      end
   endfunction

   function automatic void model_byte(input logic [7:0] b);
      if (b >= "0" && b <= "9") begin
         if (m_cnt < MAXD) begin
            exp_dig.push_back(int'(b) - 48);
            m_cnt++;
         end else begin
            model_flag(2);
         end
      end else if (b == 8'h0A) begin
         if (m_cnt > 0) begin
            m_bcnt = (m_bcnt + 1) % 65536;
            exp_len.push_back(m_cnt);
            exp_cnt.push_back(m_bcnt);
            m_cnt = 0;
         end
      end else if (b != 8'h0D) begin
         model_flag(1);
      end
   endfunction

   function automatic void clear_all();
      exp_dig.delete(); exp_len.delete(); exp_cnt.delete();
      obs_dig.delete(); obs_dcyc.delete(); obs_len.delete(); obs_cnt.delete(); obs_bcyc.delete();
      m_cnt = 0; m_bcnt = 0; m_err = 0; m_code = 0;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Called at posedge+1; returns at posedge+1 after the byte was taken.
   task automatic send_byte(input logic [7:0] b, input int full_pct);
      int waited = 0;
      bit acc = 0;
      byte_in    = b;
      byte_valid = 1'b1;
      while (!acc && waited < 100) begin
         sink_full = ($urandom_range(99) < full_pct);
         @(negedge clock);
         if (byte_ready) begin
            acc = 1;
            last_acc_cyc = cyc;
         end
         @(posedge clock); #1;
         waited++;
      end
      byte_valid = 1'b0;
      if (!acc) chk("accept_timeout", 32'(acc), 32'd1);
      else model_byte(b);
   endtask

   task automatic send_str(input string s, input int full_pct);
      for (int i = 0; i < s.len(); i++) send_byte(s[i], full_pct);
   endtask

   task automatic drain();
      byte_valid = 1'b0;
      sink_full  = 1'b0;
      repeat (8) @(posedge clock);
      #1;
   endtask

   task automatic check_all(input string tag);
      int n;
      chk({tag, "_ndig"}, 32'(obs_dig.size()), 32'(exp_dig.size()));
      n = (obs_dig.size() < exp_dig.size()) ? obs_dig.size() : exp_dig.size();
      for (int i = 0; i < n; i++) chk({tag, "_digit"}, 32'(obs_dig[i]), 32'(exp_dig[i]));
      chk({tag, "_nbanks"}, 32'(obs_len.size()), 32'(exp_len.size()));
      n = (obs_len.size() < exp_len.size()) ? obs_len.size() : exp_len.size();
      for (int i = 0; i < n; i++) begin
         chk({tag, "_bank_len"}, 32'(obs_len[i]), 32'(exp_len[i]));
         chk({tag, "_bank_count_at_done"}, 32'(obs_cnt[i]), 32'(exp_cnt[i]));
      end
      chk({tag, "_bank_count"}, 32'(bank_count), 32'(m_bcnt));
      chk({tag, "_err"}, 32'(err), 32'(m_err));
      chk({tag, "_err_code"}, 32'(err_code), 32'(m_code));
      obs_dig.delete(); obs_dcyc.delete(); obs_len.delete(); obs_cnt.delete(); obs_bcyc.delete();
      exp_dig.delete(); exp_len.delete(); exp_cnt.delete();
   endtask

   // Entered at posedge+1; asserts reset mid-cycle and checks the asynchronous clear.
   task automatic do_reset();
      reset = 1'b0;
      #1;
      chk("rst_digit_valid", 32'(digit_valid), 32'd0);
      chk("rst_digit_out", 32'(digit_out), 32'd0);
      chk("rst_bank_done", 32'(bank_done), 32'd0);
      chk("rst_bank_len", 32'(bank_len), 32'd0);
      chk("rst_bank_count", 32'(bank_count), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_err_code", 32'(err_code), 32'd0);
      chk("rst_byte_ready", 32'(byte_ready), 32'd0);
      clear_all();
      byte_valid = 1'b0;
      sink_full  = 1'b0;
      @(posedge clock); #1;
      reset = 1'b1;
      @(negedge clock);
      chk("post_rst_byte_ready", 32'(byte_ready), 32'd1);
      @(posedge clock); #1;
   endtask

   initial begin
      int nl_cyc;
      logic [7:0] b;
      int r;

      // Power-up reset
      @(posedge clock); #1;
      do_reset();

      // Basic bank with timing
      send_str("987\n", 0);
      nl_cyc = last_acc_cyc;
      drain();
      if (obs_dcyc.size() >= 3) begin
         chk("basic_digit_cycle_1", 32'(obs_dcyc[1] - obs_dcyc[0]), 32'd1);
         chk("basic_digit_cycle_2", 32'(obs_dcyc[2] - obs_dcyc[1]), 32'd1);
      end else chk("basic_digit_cycles_seen", 32'(obs_dcyc.size()), 32'd3);
      if (obs_bcyc.size() >= 1) chk("basic_done_latency", 32'(obs_bcyc[0] - nl_cyc), 32'd2);
      else chk("basic_done_seen", 32'(obs_bcyc.size()), 32'd1);
      check_all("basic");

      // Mid-bank reset with a digit held by backpressure
      send_str("12", 0);
      sink_full = 1'b1;
      @(negedge clock);
      chk("midrst_pending_valid", 32'(digit_valid), 32'd1);
      chk("midrst_pending_digit", 32'(digit_out), 32'd2);
      @(posedge clock); #1;
      do_reset();
      send_str("5\n", 0);
      drain();
      check_all("after_reset");

      // Backpressure on the first digit
      byte_in = "4"; byte_valid = 1'b1; sink_full = 1'b0;
      @(negedge clock);
      chk("bp_first_ready", 32'(byte_ready), 32'd1);
      @(posedge clock); #1;
      model_byte("4");
      byte_in = "5"; sink_full = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clock);
         chk("bp_held_digit", 32'(digit_out), 32'd4);
         chk("bp_held_valid", 32'(digit_valid), 32'd1);
         chk("bp_ready_low", 32'(byte_ready), 32'd0);
         @(posedge clock); #1;
      end
      sink_full = 1'b0;
      send_str("5\n", 0);
      drain();
      check_all("backpressure");

      // Blank lines and carriage returns
      do_reset();
      send_str("\r\n\n12\r\n", 0);
      drain();
      check_all("blank_cr");

      // Illegal character
      do_reset();
      send_str("3a4\n", 0);
      drain();
      check_all("illegal");

      // Overflow then a following bank
      do_reset();
      send_str("123456\n7\n", 0);
      drain();
      check_all("overflow");

      // Random streams with random backpressure
      for (int rep = 0; rep < 3; rep++) begin
         do_reset();
         for (int i = 0; i < 300; i++) begin
            r = $urandom_range(99);
            if (r < 62) b = 8'h30 + 8'($urandom_range(9));
            else if (r < 78) b = 8'h0A;
            else if (r < 86) b = 8'h0D;
            else if (r < 88) b = "z";
            else b = 8'h30 + 8'($urandom_range(9));
            send_byte(b, (rep == 0) ? 0 : 35);
         end
         send_byte(8'h0A, 0);
         drain();
         check_all("random");
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/bank_digit_parser.md
# bank_digit_parser

Upstream feeder for the AOC day-3 digit stack. Accepts the puzzle input as an ASCII byte stream and converts each digit character to its numeric value. Presents digits one at a time with a hold-until-consumed output register that respects the stack's `full` flag, and reports end-of-bank (newline) with a per-bank digit count. It also keeps a running bank count and sticky error flags for malformed input.

## Interface
- `MAX_DIGITS`, 128: maximum digits accepted per bank (line); must be ≥1.
- `LEN_W`, `$clog2(MAX_DIGITS)+1`: width of `bank_len`; derived, not overridden.
- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-low; all state cleared while low.
- `byte_in`  in  8  ASCII input byte.
- `byte_valid`  in  1  `byte_in` is valid.
- `byte_ready`  out  1  block accepts `byte_in` this cycle.
- `sink_full`  in  1  downstream stack full; the pending digit is not consumed.
- `digit_out`  out  `DATA_WIDTH`  digit value 0–9, zero-extended.
- `digit_valid`  out  1  `digit_out` valid; drives the stack's `data_in_valid`.
- `bank_done`  out  1  one-cycle pulse: the bank has ended and all its digits have been consumed.
- `bank_len`  out  `LEN_W`  digits emitted in the last completed bank; held until the next `bank_done`.
- `bank_count`  out  16  completed non-empty banks; wraps at 2^16.
- `err`  out  1  sticky error flag.
- `err_code`  out  2  first error only: 01 = illegal character, 10 = bank overflow; 00 = none.

## Operation
- **Byte accept:** `byte_valid && byte_ready`.
- **Digit consume:** `digit_valid && !sink_full`.
- **`byte_ready`:** `(state != CLOSE) && (!digit_valid || !sink_full)`. Forced 0 while `reset` is low.
- **States:** IDLE (no digits yet in current bank), COLLECT (≥1 digit accepted), CLOSE (newline seen, draining).
- **Byte classes on accept:**
  - `'0'`–`'9'`:
    - If the bank digit counter is below `MAX_DIGITS`: load `digit_out = byte_in - 8'h30`, set `digit_valid`, increment the counter, IDLE→COLLECT.
    - Otherwise: drop the byte and flag overflow (code 10).
  - `'\r'` (8'h0D): ignored, no state change.
  - `'\n'` (8'h0A):
    - In IDLE (empty line): ignored; no pulse, no count change.
    - In COLLECT: go to CLOSE.
  - Anything else: dropped. Flag illegal (code 01). State is unchanged and the bank continues.
- **Output register:**
  - `digit_valid` clears on consume unless a new digit loads in the same cycle; then the register reloads and stays valid.
  - `digit_out` is held stable while `digit_valid && sink_full`.
- **CLOSE:**
  - When `digit_valid == 0`, the state returns to IDLE on that edge.
  - On the same edge: `bank_done` is set for one cycle, `bank_len` captures the counter, `bank_count` increments, and the counter clears.
- **Errors:**
  - `err` is set on the first error and stays set until reset.
  - `err_code` latches the first error's code only.
  - An error never stalls the stream.
- **Arithmetic:**
  - The digit counter is `LEN_W` bits and saturates at `MAX_DIGITS`.
  - `bank_count` wraps modulo 2^16.

## Timing
- **Reset values:** `digit_valid` 0, `digit_out` 0, `bank_done` 0, `bank_len` 0, `bank_count` 0, `err` 0, `err_code` 00, state IDLE. `byte_ready` is 0 while reset is low and 1 on the first cycle after release.
- **Digit latency:** a digit accepted at cycle t appears on `digit_valid`/`digit_out` at t+1.
- **Throughput:** one digit per cycle with `sink_full` low.
- **Newline with nothing pending:** newline accepted at t with no pending digit consumed later → state CLOSE at t+1, `bank_done` at t+2, `byte_ready` high again at t+2.
- **Newline with a digit pending:** `bank_done` occurs on the cycle after the first CLOSE cycle in which `digit_valid` is 0.
- **Last digit consumed alongside newline:** the last digit consumed and the newline accepted in the same cycle is legal and gives the same t+2 timing.
- **`sink_full` in CLOSE:** extends CLOSE indefinitely. No bytes are accepted during CLOSE.
- **Reset mid-operation:**
  - The pending digit and partial bank are discarded.
  - Counters and errors are cleared.
  - No `bank_done` is emitted.

## Test plan
- **Basic bank:** `"987\n"`, `sink_full` = 0 → `digit_out` 9, 8, 7 on three consecutive cycles; `bank_done` 2 cycles after the newline is accepted; `bank_len` = 3, `bank_count` = 1, `err` = 0.
- **Backpressure:** `"45\n"` with `sink_full` high for 5 cycles after the first digit appears → `digit_out` = 4 held stable and `byte_ready` = 0 for those cycles; then 4, 5 consumed in order; `bank_len` = 2, no digit lost or duplicated.
- **Blank lines and CR:** `"\r\n\n12\r\n"` → exactly one `bank_done`; `bank_len` = 2, `bank_count` = 1, `err` = 0.
- **Illegal character:** `"3a4\n"` → digits 3, 4 only; `err` = 1, `err_code` = 01, `bank_len` = 2.
- **Overflow:** `MAX_DIGITS` = 4, `"123456\n"` → digits 1–4 only; `err_code` = 10, `bank_len` = 4; next bank `"7\n"` gives `bank_len` = 1, `bank_count` = 2.
- **Mid-bank reset:** assert `reset` low mid-bank with `digit_valid` = 1 → all outputs 0 immediately (asynchronous); after release, `"5\n"` gives `bank_len` = 1, `bank_count` = 1.
